gpio_pad_ctrl: RTL and testbench
================================

// Module: gpio_pad_ctrl
// PURPOSE
// Core-side controller for a bank of NPIN bidirectional pad cells (I/E/O data pins, PU/PD/SMT/SR/E2/E4/E8 controls).
// Registers output data and enable toward each pad, and holds per-pin configuration for pull, Schmitt, slew, drive and open-drain.
// Synchronizes and debounces pad O, then raises sticky edge interrupts. Sits directly upstream of the pad ring.
// PARAMETERS
// NPIN       8   number of pads controlled
// DB_CYCLES  4   consecutive stable cycles required before gpio_in updates (legal range 1..255)
// AW         3   cfg_addr width; must be >= $clog2(NPIN)
// PORTS
// clk        in   1     core clock
// rst_n      in   1     asynchronous reset, active low
// cfg_we     in   1     config write strobe
// cfg_addr   in   AW    pin index for write/read
// cfg_wdata  in   10    [0]PU [1]PD [2]SMT [3]SR [4]E2 [5]E4 [6]E8 [7]OD [8]IRQ_RISE_EN [9]IRQ_FALL_EN
// cfg_rdata  out  10    config of pin cfg_addr (combinational)
// gpio_out   in   NPIN  core output data
// gpio_oe    in   NPIN  core output enable
// gpio_in    out  NPIN  synchronized, debounced pad input
// irq_clr    in   NPIN  per-pin status clear pulse
// irq_status out  NPIN  sticky edge status
// irq        out  1     OR of irq_status
// pad_i      out  NPIN  to pad I
// pad_e      out  NPIN  to pad E
// pad_o      in   NPIN  from pad O (asynchronous)
// pad_pu, pad_pd, pad_smt, pad_sr, pad_e2, pad_e4, pad_e8  out  NPIN each  pad control pins
// BEHAVIOUR
// - Reset values: all config = 10'h010 (E2 only); pad_i, pad_e, gpio_in, irq_status, irq and sync flops = 0; debounce counters = 0.
// - Config write: on a clk edge with cfg_we=1 and cfg_addr<NPIN, load cfg[cfg_addr]. cfg_addr>=NPIN: write ignored, cfg_rdata=0.
// - Pad controls are driven combinationally from cfg. If PU and PD are both set: pad_pu=1, pad_pd=0 (PU wins).
// - Output path (registered, 1-cycle latency):
//   - OD=0: pad_i<=gpio_out; pad_e<=gpio_oe.
//   - OD=1: pad_i<=0; pad_e<=gpio_oe & ~gpio_out.
// - Input path: 2-flop synchronizer s1->s2 per pin.
//   - Counter cnt: if s2==gpio_in, cnt<=0.
//   - Else if cnt==DB_CYCLES-1, gpio_in<=s2 and cnt<=0.
//   - Else cnt<=cnt+1. cnt is 8 bits, saturating logic not needed.
//   - A clean pad_o step appears on gpio_in 2+DB_CYCLES edges later.
//   - A glitch shorter than DB_CYCLES cycles at s2 is dropped.
// - Edge detect on the gpio_in update edge:
//   - 0->1 with IRQ_RISE_EN sets irq_status; 1->0 with IRQ_FALL_EN sets it.
//   - irq_clr clears the bit. Set and clear in the same cycle: set wins.
//   - irq = |irq_status, registered with irq_status (no extra latency).
// - Disabling an IRQ enable does not clear an already-set status bit.
// - Config change mid-operation does not disturb sync/debounce state; OD change takes effect on pad_i/pad_e at the next edge.
// - rst_n assertion at any time: all state returns to reset values immediately (async); release is sampled by clk.
// TESTING
// - Reset: after rst_n low, pad_e=0, pad_i=0, pad_e2=all 1, other pad controls 0, irq=0, cfg_rdata(any pin)=10'h010.
// - Write cfg pin2=10'h003 -> pad_pu[2]=1, pad_pd[2]=0. Write addr 7 with NPIN=6 -> no change, cfg_rdata=0.
// - Push-pull then open-drain:
//   - OD=0, gpio_out[0]=1, gpio_oe[0]=1 -> next edge pad_i[0]=1, pad_e[0]=1.
//   - Set OD=1 -> pad_e[0]=0, pad_i[0]=0; gpio_out[0]=0 -> pad_e[0]=1.
// - Debounce, DB_CYCLES=4:
//   - pad_o[1] steps 0->1 at edge k -> gpio_in[1]=1 after edge k+6.
//   - A 3-cycle high pulse -> gpio_in[1] stays 0.
// - IRQ: IRQ_FALL_EN on pin 3, gpio_in[3] 1->0 -> irq_status[3]=1, irq=1.
//   - irq_clr[3] on the same cycle as a new edge -> status stays 1.
//   - irq_clr[3] alone -> irq=0.
// - Reset mid-debounce: counter at 2, assert rst_n -> gpio_in=0 and cnt=0; a fresh step needs the full 6 edges.

Source files
------------

// File: rtl/gpio_pad_ctrl_if.sv
// Core/pad-ring signal bundle for gpio_pad_ctrl. The master side is the core plus the pad ring;
// the slave side is the controller itself.
interface gpio_pad_ctrl_if #(
    parameter int NPIN = 8,
    parameter int AW   = 3
);
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [9:0]      cfg_wdata;
    logic [9:0]      cfg_rdata;
    logic [NPIN-1:0] gpio_out;
    logic [NPIN-1:0] gpio_oe;
    logic [NPIN-1:0] gpio_in;
    logic [NPIN-1:0] irq_clr;
    logic [NPIN-1:0] irq_status;
    logic            irq;
    logic [NPIN-1:0] pad_i;
    logic [NPIN-1:0] pad_e;
    logic [NPIN-1:0] pad_o;
    logic [NPIN-1:0] pad_pu;
    logic [NPIN-1:0] pad_pd;
    logic [NPIN-1:0] pad_smt;
    logic [NPIN-1:0] pad_sr;
    logic [NPIN-1:0] pad_e2;
    logic [NPIN-1:0] pad_e4;
    logic [NPIN-1:0] pad_e8;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, gpio_out, gpio_oe, irq_clr, pad_o,
        input  cfg_rdata, gpio_in, irq_status, irq, pad_i, pad_e,
               pad_pu, pad_pd, pad_smt, pad_sr, pad_e2, pad_e4, pad_e8
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, gpio_out, gpio_oe, irq_clr, pad_o,
        output cfg_rdata, gpio_in, irq_status, irq, pad_i, pad_e,
               pad_pu, pad_pd, pad_smt, pad_sr, pad_e2, pad_e4, pad_e8
    );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// Core-side controller for a bank of bidirectional pads: registered output path, per-pin
// pad configuration, synchronized/debounced input and sticky edge interrupts.
module gpio_pad_ctrl #(
    parameter int NPIN      = 8,
    parameter int DB_CYCLES = 4,
    parameter int AW        = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    gpio_pad_ctrl_if.slave bus
);

    localparam logic [9:0] CFG_RST = 10'h010;
    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    localparam int B_PU   = 0;
    localparam int B_PD   = 1;
    localparam int B_SMT  = 2;
    localparam int B_SR   = 3;
    localparam int B_E2   = 4;
    localparam int B_E4   = 5;
    localparam int B_E8   = 6;
    localparam int B_OD   = 7;
    localparam int B_RISE = 8;
    localparam int B_FALL = 9;

    logic [9:0]      cfg_q [NPIN];
    logic [7:0]      cnt_q [NPIN];
    logic [7:0]      cnt_d [NPIN];
    logic [NPIN-1:0] s1_q, s2_q;
    logic [NPIN-1:0] gpio_in_q, gpio_in_d;
    logic [NPIN-1:0] irq_status_q, irq_status_d;
    logic            irq_q;
    logic [NPIN-1:0] pad_i_q, pad_i_d;
    logic [NPIN-1:0] pad_e_q, pad_e_d;
    logic [NPIN-1:0] edge_set;

    logic [NPIN-1:0] pu_v, pd_v, smt_v, sr_v, e2_v, e4_v, e8_v;
    logic [9:0]      rdata_v;

    // Pad controls follow config directly; PU suppresses PD so the pad never sees both pulls.
    always_comb begin
        pu_v    = '0;
        pd_v    = '0;
        smt_v   = '0;
        sr_v    = '0;
        e2_v    = '0;
        e4_v    = '0;
        e8_v    = '0;
        rdata_v = '0;
        for (int i = 0; i < NPIN; i++) begin
            pu_v[i]  = cfg_q[i][B_PU];
            pd_v[i]  = cfg_q[i][B_PD] & ~cfg_q[i][B_PU];
            smt_v[i] = cfg_q[i][B_SMT];
            sr_v[i]  = cfg_q[i][B_SR];
            e2_v[i]  = cfg_q[i][B_E2];
            e4_v[i]  = cfg_q[i][B_E4];
            e8_v[i]  = cfg_q[i][B_E8];
            if (bus.cfg_addr == AW'(i)) begin
                rdata_v = cfg_q[i];
            end
        end
    end

    assign bus.pad_pu     = pu_v;
    assign bus.pad_pd     = pd_v;
    assign bus.pad_smt    = smt_v;
    assign bus.pad_sr     = sr_v;
    assign bus.pad_e2     = e2_v;
    assign bus.pad_e4     = e4_v;
    assign bus.pad_e8     = e8_v;
    assign bus.cfg_rdata  = rdata_v;
    assign bus.pad_i      = pad_i_q;
    assign bus.pad_e      = pad_e_q;
    assign bus.gpio_in    = gpio_in_q;
    assign bus.irq_status = irq_status_q;
    assign bus.irq        = irq_q;

    // Debounce: gpio_in only moves after s2 has disagreed with it for DB_CYCLES edges in a row.
    always_comb begin
        gpio_in_d = gpio_in_q;
        edge_set  = '0;
        pad_i_d   = '0;
        pad_e_d   = '0;
        for (int i = 0; i < NPIN; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < NPIN; i++) begin
            if (s2_q[i] == gpio_in_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                gpio_in_d[i] = s2_q[i];
                cnt_d[i]     = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
            edge_set[i] = (gpio_in_d[i] & ~gpio_in_q[i] & cfg_q[i][B_RISE]) |
                          (~gpio_in_d[i] & gpio_in_q[i] & cfg_q[i][B_FALL]);
            // Open drain only ever drives low: enable the driver when the core wants a 0.
            if (cfg_q[i][B_OD]) begin
                pad_i_d[i] = 1'b0;
                pad_e_d[i] = bus.gpio_oe[i] & ~bus.gpio_out[i];
            end else begin
                pad_i_d[i] = bus.gpio_out[i];
                pad_e_d[i] = bus.gpio_oe[i];
            end
        end
        irq_status_d = (irq_status_q & ~bus.irq_clr) | edge_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIN; i++) begin
                cfg_q[i] <= CFG_RST;
                cnt_q[i] <= '0;
            end
            s1_q         <= '0;
            s2_q         <= '0;
            gpio_in_q    <= '0;
            irq_status_q <= '0;
            irq_q        <= 1'b0;
            pad_i_q      <= '0;
            pad_e_q      <= '0;
        end else begin
            for (int i = 0; i < NPIN; i++) begin
                if (bus.cfg_we && (bus.cfg_addr == AW'(i))) begin
                    cfg_q[i] <= bus.cfg_wdata;
                end
                cnt_q[i] <= cnt_d[i];
            end
            s1_q         <= bus.pad_o;
            s2_q         <= s1_q;
            gpio_in_q    <= gpio_in_d;
            irq_status_q <= irq_status_d;
            irq_q        <= |irq_status_d;
            pad_i_q      <= pad_i_d;
            pad_e_q      <= pad_e_d;
        end
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed scenarios plus random traffic, all checked against a
// window-based reference model of the pin rules.
module tb_gpio_pad_ctrl;
    localparam int NPIN = 6;
    localparam int DB   = 4;
    localparam int AW   = 3;

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [9:0]      wdata;
        logic [NPIN-1:0] out;
        logic [NPIN-1:0] oe;
        logic [NPIN-1:0] clr;
        logic [NPIN-1:0] padO;
    } StimT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpio_pad_ctrl_if #(.NPIN(NPIN), .AW(AW)) bus ();

    gpio_pad_ctrl #(.NPIN(NPIN), .DB_CYCLES(DB), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    StimT stim;

    logic [9:0]      mCfg [NPIN];
    logic [NPIN-1:0] mPadI, mPadE, mIn, mStat, mDly1, mDly2;
    logic            mIrq;
    logic [NPIN-1:0] mWin [$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void modelReset();
        for (int p = 0; p < NPIN; p++) mCfg[p] = 10'h010;
        mPadI = '0; mPadE = '0; mIn = '0; mStat = '0; mDly1 = '0; mDly2 = '0; mIrq = 1'b0;
        mWin.delete();
        for (int k = 0; k < DB; k++) mWin.push_back('0);
    endfunction

    // Input rule: a pin flips once the last DB synchronized samples all show the opposite level.
    function automatic void modelAdvance();
        logic [NPIN-1:0] newIn, setBits, w;
        logic stable;
        mWin.push_back(mDly2);
        void'(mWin.pop_front());
        setBits = '0;
        for (int p = 0; p < NPIN; p++) begin
            stable = 1'b1;
            for (int k = 0; k < DB; k++) begin
                w = mWin[k];
                if (w[p] == mIn[p]) stable = 1'b0;
            end
            newIn[p] = stable ? ~mIn[p] : mIn[p];
            if (newIn[p] && !mIn[p] && mCfg[p][8]) setBits[p] = 1'b1;
            if (!newIn[p] && mIn[p] && mCfg[p][9]) setBits[p] = 1'b1;
            if (mCfg[p][7]) begin
                mPadI[p] = 1'b0;
                mPadE[p] = stim.oe[p] && !stim.out[p];
            end else begin
                mPadI[p] = stim.out[p];
                mPadE[p] = stim.oe[p];
            end
        end
        mStat = (mStat & ~stim.clr) | setBits;
        mIrq  = (mStat != '0);
        mIn   = newIn;
        if (stim.we && int'(stim.addr) < NPIN) mCfg[int'(stim.addr)] = stim.wdata;
        mDly2 = mDly1;
        mDly1 = stim.padO;
    endfunction

    task automatic checkComb();
        logic [NPIN-1:0] pu, pd, smt, sr, e2, e4, e8;
        logic [9:0] rd;
        for (int p = 0; p < NPIN; p++) begin
            pu[p]  = mCfg[p][0];
            pd[p]  = mCfg[p][1] && !mCfg[p][0];
            smt[p] = mCfg[p][2];
            sr[p]  = mCfg[p][3];
            e2[p]  = mCfg[p][4];
            e4[p]  = mCfg[p][5];
            e8[p]  = mCfg[p][6];
        end
        rd = (int'(bus.cfg_addr) < NPIN) ? mCfg[int'(bus.cfg_addr)] : 10'h000;
        checkOutput("cfg_rdata", 32'(bus.cfg_rdata), 32'(rd));
        checkOutput("pad_pu", 32'(bus.pad_pu), 32'(pu));
        checkOutput("pad_pd", 32'(bus.pad_pd), 32'(pd));
        checkOutput("pad_smt", 32'(bus.pad_smt), 32'(smt));
        checkOutput("pad_sr", 32'(bus.pad_sr), 32'(sr));
        checkOutput("pad_e2", 32'(bus.pad_e2), 32'(e2));
        checkOutput("pad_e4", 32'(bus.pad_e4), 32'(e4));
        checkOutput("pad_e8", 32'(bus.pad_e8), 32'(e8));
    endtask

    task automatic checkRegs();
        checkOutput("pad_i", 32'(bus.pad_i), 32'(mPadI));
        checkOutput("pad_e", 32'(bus.pad_e), 32'(mPadE));
        checkOutput("gpio_in", 32'(bus.gpio_in), 32'(mIn));
        checkOutput("irq_status", 32'(bus.irq_status), 32'(mStat));
        checkOutput("irq", 32'(bus.irq), 32'(mIrq));
    endtask

    // One clock: drive at the falling edge, check combinational paths, then registered results.
    task automatic applyStimulus();
        bus.cfg_we    = stim.we;
        bus.cfg_addr  = stim.addr;
        bus.cfg_wdata = stim.wdata;
        bus.gpio_out  = stim.out;
        bus.gpio_oe   = stim.oe;
        bus.irq_clr   = stim.clr;
        bus.pad_o     = stim.padO;
        #1;
        checkComb();
        modelAdvance();
        @(posedge clk);
        @(negedge clk);
        checkRegs();
        stim.we  = 1'b0;
        stim.clr = '0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #2;
        modelReset();
        checkRegs();
        checkComb();
        checkOutput("rst_pad_e", 32'(bus.pad_e), 0);
        checkOutput("rst_pad_i", 32'(bus.pad_i), 0);
        checkOutput("rst_gpio_in", 32'(bus.gpio_in), 0);
        checkOutput("rst_pad_e2", 32'(bus.pad_e2), 32'h3f);
        checkOutput("rst_pad_pu", 32'(bus.pad_pu | bus.pad_pd | bus.pad_smt | bus.pad_sr), 0);
        checkOutput("rst_pad_e48", 32'(bus.pad_e4 | bus.pad_e8), 0);
        checkOutput("rst_irq", 32'(bus.irq), 0);
        for (int a = 0; a < NPIN; a++) begin
            bus.cfg_addr = AW'(a);
            #1;
            checkOutput("rst_rdata", 32'(bus.cfg_rdata), 32'h010);
        end
        bus.cfg_addr = stim.addr;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic writeCfg(input int addr, input logic [9:0] data);
        stim.we    = 1'b1;
        stim.addr  = AW'(addr);
        stim.wdata = data;
        applyStimulus();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    initial begin
        stim.we = 1'b0; stim.addr = '0; stim.wdata = '0; stim.out = '0;
        stim.oe = '0; stim.clr = '0; stim.padO = '0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.gpio_out = '0;
        bus.gpio_oe = '0; bus.irq_clr = '0; bus.pad_o = '0;
        @(negedge clk);
        doReset();

        writeCfg(2, 10'h003);
        checkOutput("pu_wins_pu2", 32'(bus.pad_pu[2]), 1);
        checkOutput("pu_wins_pd2", 32'(bus.pad_pd[2]), 0);
        writeCfg(7, 10'h3ff);
        checkOutput("oob_rdata", 32'(bus.cfg_rdata), 0);
        idle(1);

        stim.out[0] = 1'b1; stim.oe[0] = 1'b1;
        applyStimulus();
        checkOutput("pp_pad_i0", 32'(bus.pad_i[0]), 1);
        checkOutput("pp_pad_e0", 32'(bus.pad_e[0]), 1);
        writeCfg(0, 10'h090);
        applyStimulus();
        checkOutput("od_pad_i0", 32'(bus.pad_i[0]), 0);
        checkOutput("od_pad_e0", 32'(bus.pad_e[0]), 0);
        stim.out[0] = 1'b0;
        applyStimulus();
        checkOutput("od_low_pad_e0", 32'(bus.pad_e[0]), 1);
        writeCfg(0, 10'h010);

        stim.padO[1] = 1'b1;
        idle(3);
        stim.padO[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
            checkOutput("glitch_in1", 32'(bus.gpio_in[1]), 0);
        end
        stim.padO[1] = 1'b1;
        idle(5);
        checkOutput("step_early_in1", 32'(bus.gpio_in[1]), 0);
        applyStimulus();
        checkOutput("step_in1", 32'(bus.gpio_in[1]), 1);

        writeCfg(3, 10'h210);
        stim.padO[3] = 1'b1;
        idle(8);
        checkOutput("rise_no_en", 32'(bus.irq_status[3]), 0);
        stim.padO[3] = 1'b0;
        idle(6);
        checkOutput("fall_stat3", 32'(bus.irq_status[3]), 1);
        checkOutput("fall_irq", 32'(bus.irq), 1);
        writeCfg(3, 10'h310);
        stim.padO[3] = 1'b1;
        idle(5);
        stim.clr[3] = 1'b1;
        applyStimulus();
        checkOutput("set_beats_clr", 32'(bus.irq_status[3]), 1);
        writeCfg(3, 10'h010);
        checkOutput("disable_keeps", 32'(bus.irq_status[3]), 1);
        stim.clr[3] = 1'b1;
        applyStimulus();
        checkOutput("clr_stat3", 32'(bus.irq_status[3]), 0);
        checkOutput("clr_irq", 32'(bus.irq), 0);

        stim.padO = '0;
        idle(8);
        stim.padO[1] = 1'b1;
        idle(4);
        doReset();
        checkOutput("rst_mid_in1", 32'(bus.gpio_in[1]), 0);
        idle(5);
        checkOutput("rst_step_early", 32'(bus.gpio_in[1]), 0);
        applyStimulus();
        checkOutput("rst_step_in1", 32'(bus.gpio_in[1]), 1);

        for (int c = 0; c < 600; c++) begin
            logic [NPIN-1:0] flip;
            if (c == 300) doReset();
            stim.we    = ($urandom % 4) == 0;
            stim.addr  = AW'($urandom % 8);
            stim.wdata = 10'($urandom);
            stim.out   = NPIN'($urandom);
            stim.oe    = NPIN'($urandom);
            stim.clr   = (($urandom % 6) == 0) ? NPIN'($urandom) : '0;
            flip = '0;
            for (int p = 0; p < NPIN; p++) flip[p] = ($urandom % 7) == 0;
            stim.padO = stim.padO ^ flip;
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
